// File: rtl/multi_mode_ff_bank.sv
// ---------------------------------------------------------------------------
// multi_mode_ff_bank
//
// A bank of WIDTH independent flip-flops. All bits share one clock, one reset
// and one mode select. Each rising edge with en=1 updates every bit according
// to the selected flip-flop personality:
//   mode 00 SR : (a,b) 00 hold, 10 set, 01 clear, 11 per SR_ILLEGAL policy
//   mode 01 JK : (a,b) 00 hold, 10 set, 01 clear, 11 toggle
//   mode 10 D  : q = a
//   mode 11 T  : a=1 toggles, a=0 holds
// The S=R=1 combination in SR mode is tracked as an "illegal" event. It sets
// a sticky per-bit flag and bumps a saturating counter once per edge.
//
// Parameters
//   WIDTH      number of flip-flop bits
//   RESET_VAL  value of q while/after reset
//   SR_ILLEGAL S=R=1 next state: 0 hold, 1 set, 2 clear, other values hold
//   CNT_W      width of the illegal-event counter
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   mode      in   [1:0] flip-flop personality, sampled every edge
//   en        in   clock enable for q, err_flag and err_cnt
//   a         in   [WIDTH-1:0] S / J / D / T input
//   b         in   [WIDTH-1:0] R / K input (unused in D and T modes)
//   clr_err   in   synchronous clear of err_flag/err_cnt (only when en=1)
//   q         out  [WIDTH-1:0] registered state
//   qbar      out  [WIDTH-1:0] complement of q
//   err_flag  out  [WIDTH-1:0] sticky per-bit SR-illegal indicator
//   err_cnt   out  [CNT_W-1:0] saturating count of edges with an illegal bit
// ---------------------------------------------------------------------------
module multi_mode_ff_bank #(
    parameter int                WIDTH      = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
    parameter int                SR_ILLEGAL = 0,
    parameter int                CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic [WIDTH-1:0]  err_flag,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] err_flag_q, err_flag_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] illegal_mask;
    logic [WIDTH-1:0] flag_base;
    logic [CNT_W-1:0] cnt_base;

    // S=R=1 in SR mode only; JK 11 is a legitimate toggle.
    assign illegal_mask = (mode == MODE_SR) ? (a & b) : '0;

    // Per-bit next state, computed as if en=1; en gating happens below.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode)
                MODE_SR: begin
                    unique case ({a[i], b[i]})
                        2'b10:   q_d[i] = 1'b1;
                        2'b01:   q_d[i] = 1'b0;
                        2'b11: begin
                            if (SR_ILLEGAL == 1)      q_d[i] = 1'b1;
                            else if (SR_ILLEGAL == 2) q_d[i] = 1'b0;
                            else                      q_d[i] = q_q[i];
                        end
                        default: q_d[i] = q_q[i];
                    endcase
                end
                MODE_JK: begin
                    unique case ({a[i], b[i]})
                        2'b10:   q_d[i] = 1'b1;
                        2'b01:   q_d[i] = 1'b0;
                        2'b11:   q_d[i] = ~q_q[i];
                        default: q_d[i] = q_q[i];
                    endcase
                end
                MODE_D:  q_d[i] = a[i];
                MODE_T:  q_d[i] = q_q[i] ^ a[i];
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // Clear is applied first, then this edge's events are merged in, so a
    // clear coinciding with an illegal edge leaves exactly that edge's record.
    always_comb begin
        flag_base  = clr_err ? '0 : err_flag_q;
        cnt_base   = clr_err ? '0 : err_cnt_q;
        err_flag_d = flag_base | illegal_mask;
        err_cnt_d  = cnt_base;
        if (|illegal_mask) begin
            if (cnt_base != CNT_MAX) begin
                err_cnt_d = cnt_base + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= RESET_VAL;
            err_flag_q <= '0;
            err_cnt_q  <= '0;
        end else if (en) begin
            q_q        <= q_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign q        = q_q;
    assign qbar     = ~q_q;
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_multi_mode_ff_bank
//
// Four instances share one set of inputs:
//   dut_main : defaults (WIDTH=4, RESET_VAL=0, SR_ILLEGAL=0, CNT_W=8)
//   dut_sat  : CNT_W=2, for counter saturation
//   dut_p1   : SR_ILLEGAL=1 (S=R=1 sets)
//   dut_p2   : SR_ILLEGAL=2 (S=R=1 clears)
// Stimulus pushes hand-computed expectations into per-instance queues; the
// monitor pops and compares shortly after every rising clock edge and every
// falling rst_n edge.
// ---------------------------------------------------------------------------
module tb_multi_mode_ff_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_err;

    logic [3:0] m_q, m_qbar, m_flag;
    logic [7:0] m_cnt;
    logic [3:0] s_q, s_qbar, s_flag;
    logic [1:0] s_cnt;
    logic [3:0] p1_q, p1_qbar, p1_flag;
    logic [7:0] p1_cnt;
    logic [3:0] p2_q, p2_qbar, p2_flag;
    logic [7:0] p2_cnt;

    int checks;
    int passed;
    int fails;

    // {q, qbar, err_flag, err_cnt}
    logic [19:0] exp_main_q[$];
    logic [1:0]  exp_sat_q[$];
    logic [3:0]  exp_p1_q[$];
    logic [3:0]  exp_p2_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_ILLEGAL(0), .CNT_W(8)) dut_main (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .clr_err(clr_err),
        .q(m_q), .qbar(m_qbar), .err_flag(m_flag), .err_cnt(m_cnt));

    multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_ILLEGAL(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .clr_err(clr_err),
        .q(s_q), .qbar(s_qbar), .err_flag(s_flag), .err_cnt(s_cnt));

    multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_ILLEGAL(1), .CNT_W(8)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .clr_err(clr_err),
        .q(p1_q), .qbar(p1_qbar), .err_flag(p1_flag), .err_cnt(p1_cnt));

    multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_ILLEGAL(2), .CNT_W(8)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .a(a), .b(b), .clr_err(clr_err),
        .q(p2_q), .qbar(p2_qbar), .err_flag(p2_flag), .err_cnt(p2_cnt));

    // ---------------- scoreboard compare ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [19:0] e;
        logic [1:0]  es;
        logic [3:0]  ep;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_main_q.size() > 0) begin
                e = exp_main_q.pop_front();
                check("main_q",    {4'b0, m_q},    {4'b0, e[19:16]});
                check("main_qbar", {4'b0, m_qbar}, {4'b0, e[15:12]});
                check("main_flag", {4'b0, m_flag}, {4'b0, e[11:8]});
                check("main_cnt",  m_cnt,          e[7:0]);
            end
            if (exp_sat_q.size() > 0) begin
                es = exp_sat_q.pop_front();
                check("sat_cnt", {6'b0, s_cnt}, {6'b0, es});
            end
            if (exp_p1_q.size() > 0) begin
                ep = exp_p1_q.pop_front();
                check("pol1_q", {4'b0, p1_q}, {4'b0, ep});
            end
            if (exp_p2_q.size() > 0) begin
                ep = exp_p2_q.pop_front();
                check("pol2_q", {4'b0, p2_q}, {4'b0, ep});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_main(input logic [3:0] eq, input logic [3:0] ef, input logic [7:0] ec);
        logic [3:0] eqb;
        eqb = ~eq;
        exp_main_q.push_back({eq, eqb, ef, ec});
    endtask

    // Called at a falling clock edge: drives inputs for the next rising edge,
    // queues what that edge must produce, then advances to the next falling edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv,
                        input logic c, input logic [3:0] eq, input logic [3:0] ef, input logic [7:0] ec,
                        input bit ck_sat, input logic [1:0] esat,
                        input bit ck_pol, input logic [3:0] ep1, input logic [3:0] ep2);
        en = e; mode = m; a = av; b = bv; clr_err = c;
        push_main(eq, ef, ec);
        if (ck_sat) exp_sat_q.push_back(esat);
        if (ck_pol) begin
            exp_p1_q.push_back(ep1);
            exp_p2_q.push_back(ep2);
        end
        @(negedge clk);
    endtask

    task automatic push_reset_all();
        push_main(4'b0000, 4'b0000, 8'd0);
        exp_sat_q.push_back(2'd0);
        exp_p1_q.push_back(4'b0000);
        exp_p2_q.push_back(4'b0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; passed = 0; fails = 0;
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; a = 4'b0; b = 4'b0; clr_err = 1'b0;

        // Power-on reset, asserted between edges.
        #3;
        push_reset_all();
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        @(negedge clk);

        // D load 1111
        step(1, 2'b10, 4'b1111, 4'b0000, 0, 4'b1111, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);

        // Reset pulse between edges: q clears before the next edge.
        en = 1'b0;
        push_reset_all();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        push_main(4'b0000, 4'b0000, 8'd0);   // en=0 edge after release: holds
        @(negedge clk);

        // SR set/clear, then all-illegal (hold policy)
        step(1, 2'b00, 4'b0011, 4'b1100, 0, 4'b0011, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0011, 4'b1111, 8'd1, 1, 2'd1, 1, 4'b1111, 4'b0000);
        // en=0: illegal pattern and clr_err both ignored
        step(0, 2'b00, 4'b0001, 4'b0001, 0, 4'b0011, 4'b1111, 8'd1, 1, 2'd1, 0, 4'b0, 4'b0);
        step(0, 2'b01, 4'b0000, 4'b0000, 1, 4'b0011, 4'b1111, 8'd1, 1, 2'd1, 0, 4'b0, 4'b0);
        // clr_err with en=1 clears errors, q unaffected (JK hold)
        step(1, 2'b01, 4'b0000, 4'b0000, 1, 4'b0011, 4'b0000, 8'd0, 1, 2'd0, 0, 4'b0, 4'b0);

        // JK / T
        step(1, 2'b10, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b01, 4'b1111, 4'b1111, 0, 4'b1010, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b11, 4'b0011, 4'b0000, 0, 4'b1001, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);

        // D with enable, b toggling irrelevant
        step(0, 2'b10, 4'b1010, 4'b0101, 0, 4'b1001, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b10, 4'b1010, 4'b1111, 0, 4'b1010, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b10, 4'b1010, 4'b0000, 0, 4'b1010, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);

        // Mixed per-bit JK and SR
        step(1, 2'b01, 4'b0001, 4'b1000, 0, 4'b0011, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b0100, 4'b0001, 0, 4'b0110, 4'b0000, 8'd0, 0, 2'd0, 0, 4'b0, 4'b0);

        // Counting and saturation (CNT_W=2 instance: 1,2,3,3)
        step(1, 2'b00, 4'b0010, 4'b0010, 0, 4'b0110, 4'b0010, 8'd1, 1, 2'd1, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0110, 4'b1111, 8'd2, 1, 2'd2, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0110, 4'b1111, 8'd3, 1, 2'd3, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0110, 4'b1111, 8'd4, 1, 2'd3, 0, 4'b0, 4'b0);
        // clr_err coinciding with an illegal edge
        step(1, 2'b00, 4'b0100, 4'b0100, 1, 4'b0110, 4'b0100, 8'd1, 1, 2'd1, 0, 4'b0, 4'b0);
        step(1, 2'b00, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0000, 8'd0, 1, 2'd0, 0, 4'b0, 4'b0);

        // Illegal-policy instances from q=0101
        step(1, 2'b10, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 8'd0, 0, 2'd0, 1, 4'b0101, 4'b0101);
        step(1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0101, 4'b1111, 8'd1, 0, 2'd0, 1, 4'b1111, 4'b0000);

        // Reset held across an edge with active inputs, then normal first edge
        en = 1'b1; mode = 2'b10; a = 4'b1100; b = 4'b0000; clr_err = 1'b0;
        push_reset_all();
        rst_n = 1'b0;
        #2;
        push_reset_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2'b10, 4'b1100, 4'b0000, 0, 4'b1100, 4'b0000, 8'd0, 1, 2'd0, 1, 4'b1100, 4'b1100);

        // Drain: every queued expectation must be consumed within a few edges.
        for (int i = 0; i < 5; i++) begin
            if (exp_main_q.size() == 0 && exp_sat_q.size() == 0 &&
                exp_p1_q.size() == 0 && exp_p2_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_main_q.size() == 0 && exp_sat_q.size() == 0 &&
            exp_p1_q.size() == 0 && exp_p2_q.size() == 0) begin
            passed++;
        end else begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     exp_main_q.size() + exp_sat_q.size() + exp_p1_q.size() + exp_p2_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
